// File: rtl/cdc_hs_ctrl_if.sv
// Handshake bundle between a valid/ready producer, the cdc_hs_ctrl source
// controller and the clock-domain-crossing synchronizers.
interface cdc_hs_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic [DATA_W-1:0] xfer_data;
    logic              xfer_req;
    logic              ack_sync;
    logic              busy;
    logic [CNT_W-1:0]  xfer_cnt;
    logic              err;

    modport master (
        input  in_valid, in_data, ack_sync,
        output in_ready, xfer_data, xfer_req, busy, xfer_cnt, err
    );

    modport slave (
        output in_valid, in_data, ack_sync,
        input  in_ready, xfer_data, xfer_req, busy, xfer_cnt, err
    );
endinterface

// File: rtl/cdc_hs_ctrl.sv
// Source-side controller for a two-phase toggle req/ack word crossing out of clk_a.
// Optional acknowledge timeout and sticky err flag: define HS_TIMEOUT_EN.
module cdc_hs_ctrl #(
    parameter int DATA_W  = 8,
    parameter int SETTLE  = 2,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic          clk_a,
    input  logic          rst_a,
    cdc_hs_ctrl_if.master hs
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        WAIT_ACK
`ifdef HS_TIMEOUT_EN
        , ERR
`endif
    } state_t;

    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE - 1);

    if (SETTLE < 1 || SETTLE > 255 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_param
        $error("cdc_hs_ctrl: SETTLE or TIMEOUT outside its legal range");
    end

    state_t            state_q, state_d;
    logic              req_q, req_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        settle_q, settle_d;
    logic              busy_q;
    logic              ready_c;

`ifdef HS_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
    logic [15:0]       tmo_q, tmo_d;
    logic              err_q, err_d;
`endif

    always_ff @(posedge clk_a) begin
        if (rst_a) begin
            state_q  <= IDLE;
            req_q    <= 1'b0;
            data_q   <= '0;
            cnt_q    <= '0;
            settle_q <= '0;
            busy_q   <= 1'b0;
`ifdef HS_TIMEOUT_EN
            tmo_q    <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            data_q   <= data_d;
            cnt_q    <= cnt_d;
            settle_q <= settle_d;
            busy_q   <= (state_d != IDLE);
`ifdef HS_TIMEOUT_EN
            tmo_q    <= tmo_d;
            err_q    <= err_d;
`endif
        end
    end

    // A req/ack mismatch in IDLE means the far side has not realigned after reset.
    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        data_d   = data_q;
        cnt_d    = cnt_q;
        settle_d = settle_q;
        ready_c  = 1'b0;
`ifdef HS_TIMEOUT_EN
        tmo_d    = tmo_q;
        err_d    = err_q;
`endif
        case (state_q)
            IDLE: begin
                ready_c = (hs.ack_sync == req_q);
                if (hs.in_valid && ready_c) begin
                    data_d   = hs.in_data;
                    settle_d = SETTLE_LOAD;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                if (settle_q == 8'd0) begin
                    req_d   = ~req_q;
                    state_d = WAIT_ACK;
`ifdef HS_TIMEOUT_EN
                    tmo_d   = '0;
`endif
                end else begin
                    settle_d = settle_q - 8'd1;
                end
            end
            WAIT_ACK: begin
                // An acknowledge on the final timeout cycle still completes the transfer.
                if (hs.ack_sync == req_q) begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = IDLE;
                end
`ifdef HS_TIMEOUT_EN
                else if (tmo_q == TMO_LAST) begin
                    state_d = ERR;
                    err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
`endif
            end
`ifdef HS_TIMEOUT_EN
            ERR: begin
                err_d = 1'b1;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign hs.in_ready  = ready_c;
    assign hs.xfer_data = data_q;
    assign hs.xfer_req  = req_q;
    assign hs.busy      = busy_q;
    assign hs.xfer_cnt  = cnt_q;
`ifdef HS_TIMEOUT_EN
    assign hs.err       = err_q;
`else
    assign hs.err       = 1'b0;
`endif

endmodule

// File: tb/tb_cdc_hs_ctrl.sv
// Self-checking bench for cdc_hs_ctrl: randomized ack loopback against a
// cycle-timed transfer model; timeout cases run only with HS_TIMEOUT_EN.
module tb_cdc_hs_ctrl;

    localparam int DATA_W  = 8;
    localparam int CNT_W   = 8;
    localparam int SETTLE  = 2;
    localparam int TIMEOUT = 10;

    logic clk_a = 1'b0;
    logic rst_a;

    always #5 clk_a = ~clk_a;

    cdc_hs_ctrl_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) hs ();

    cdc_hs_ctrl #(
        .DATA_W (DATA_W),
        .SETTLE (SETTLE),
        .TIMEOUT(TIMEOUT),
        .CNT_W  (CNT_W)
    ) dut (
        .clk_a(clk_a),
        .rst_a(rst_a),
        .hs   (hs)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Model: a transfer is a word accepted at edge N, a request toggle due at
    // N+SETTLE, and completion at the first later edge where ack equals req.
    bit              m_req;
    bit              m_busy;
    bit              m_err;
    logic [7:0]      m_data;
    int              m_cnt;
    int              m_toggle_at;
    int              m_wait_from;
    int              accepted;
    int              completed;
    logic [7:0]      exp_q[$];

    bit              ack_val;
    bit              auto_ack;
    int              fixed_delay;
    int              ack_at;
    logic            prev_req;
    int              dut_err_cyc;
    logic [7:0]      words[300];

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=0x%0h expected=0x%0h cycle=%0d", tag, got, exp, cyc);
        end
    endtask

    task automatic modelStep(input bit r, input bit v, input logic [7:0] d);
        if (r) begin
            m_req       = 1'b0;
            m_busy      = 1'b0;
            m_err       = 1'b0;
            m_data      = 8'h00;
            m_cnt       = 0;
            m_toggle_at = -1;
            m_wait_from = -1;
            accepted    = 0;
            completed   = 0;
            ack_at      = -1;
            exp_q.delete();
        end else if (m_err) begin
            m_err = 1'b1;
        end else if (!m_busy) begin
            if (v && (ack_val == m_req)) begin
                m_data      = d;
                m_busy      = 1'b1;
                m_toggle_at = cyc + SETTLE;
                m_wait_from = -1;
                accepted++;
                exp_q.push_back(d);
            end
        end else if (m_wait_from < 0) begin
            if (cyc == m_toggle_at) begin
                m_req       = !m_req;
                m_wait_from = cyc;
                if (auto_ack)
                    ack_at = cyc + ((fixed_delay > 0) ? fixed_delay : int'($urandom_range(1, 6)));
            end
        end else begin
            if (ack_val == m_req) begin
                m_cnt  = (m_cnt + 1) % (1 << CNT_W);
                m_busy = 1'b0;
                completed++;
            end
`ifdef HS_TIMEOUT_EN
            else if (cyc - m_wait_from == TIMEOUT) begin
                m_err = 1'b1;
            end
`endif
        end
    endtask

    task automatic compareAll(input bit r);
        checkOutput("xfer_req", 32'(hs.xfer_req), 32'(m_req));
        checkOutput("xfer_data", 32'(hs.xfer_data), 32'(m_data));
        checkOutput("xfer_cnt", 32'(hs.xfer_cnt), 32'(m_cnt));
        checkOutput("busy", 32'(hs.busy), 32'(m_busy));
        checkOutput("err", 32'(hs.err), 32'(m_err));
        checkOutput("in_ready", 32'(hs.in_ready), 32'(!m_busy && (ack_val == m_req)));
        if (!r && (hs.xfer_req !== prev_req)) begin
            checkOutput("sb_depth", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0)
                checkOutput("sb_word", 32'(hs.xfer_data), 32'(exp_q.pop_front()));
        end
        prev_req = hs.xfer_req;
        if ((hs.err === 1'b1) && (dut_err_cyc < 0))
            dut_err_cyc = cyc;
    endtask

    // Inputs change 2 time units after an edge; outputs are sampled there too.
    task automatic applyStimulus(input bit r, input bit v, input logic [7:0] d);
        rst_a       = r;
        hs.in_valid = v;
        hs.in_data  = d;
        hs.ack_sync = ack_val;
        @(posedge clk_a);
        cyc++;
        modelStep(r, v, d);
        #1;
        if (auto_ack && (ack_at >= 0) && (cyc == ack_at - 1)) begin
            ack_val = m_req;
            ack_at  = -1;
        end
        hs.ack_sync = ack_val;
        #1;
        compareAll(r);
    endtask

    task automatic resetFor(input int n);
        ack_val = 1'b0;
        for (int i = 0; i < n; i++)
            applyStimulus(1'b1, 1'b0, 8'h00);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired cycle=%0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        ack_val     = 1'b0;
        auto_ack    = 1'b0;
        fixed_delay = 0;
        ack_at      = -1;
        dut_err_cyc = -1;
        prev_req    = 1'b0;
        for (int i = 0; i < 300; i++)
            words[i] = 8'($urandom);

        resetFor(3);
        checkOutput("rst_req", 32'(hs.xfer_req), 32'd0);
        checkOutput("rst_data", 32'(hs.xfer_data), 32'd0);
        checkOutput("rst_cnt", 32'(hs.xfer_cnt), 32'd0);
        checkOutput("rst_ready", 32'(hs.in_ready), 32'd1);
        checkOutput("rst_busy", 32'(hs.busy), 32'd0);
        checkOutput("rst_err", 32'(hs.err), 32'd0);

        // Two words, fixed 2-cycle loopback, valid held so the second accept is earliest.
        auto_ack    = 1'b1;
        fixed_delay = 2;
        for (int i = 0; i < 30 && completed < 2; i++)
            applyStimulus(1'b0, accepted < 2, (accepted == 0) ? 8'hA5 : 8'h3C);
        checkOutput("single_cnt", 32'(hs.xfer_cnt), 32'd2);
        checkOutput("single_data", 32'(hs.xfer_data), 32'h3C);

        resetFor(2);
        ack_val  = 1'b1;
        auto_ack = 1'b0;
        for (int i = 0; i < 6; i++)
            applyStimulus(1'b0, 1'b1, 8'h77);
        checkOutput("misalign_busy", 32'(hs.busy), 32'd0);
        checkOutput("misalign_ready", 32'(hs.in_ready), 32'd0);
        ack_val     = 1'b0;
        auto_ack    = 1'b1;
        fixed_delay = 1;
        for (int i = 0; i < 20 && completed < 1; i++)
            applyStimulus(1'b0, accepted < 1, 8'h77);
        checkOutput("misalign_cnt", 32'(hs.xfer_cnt), 32'd1);
        checkOutput("misalign_data", 32'(hs.xfer_data), 32'h77);

        resetFor(2);
        auto_ack = 1'b0;
        applyStimulus(1'b0, 1'b1, 8'h5A);
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("midrst_in_setup", 32'(hs.busy), 32'd1);
        applyStimulus(1'b1, 1'b0, 8'h00);
        checkOutput("midrst_setup_data", 32'(hs.xfer_data), 32'd0);
        checkOutput("midrst_setup_cnt", 32'(hs.xfer_cnt), 32'd0);
        applyStimulus(1'b0, 1'b1, 8'hC3);
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("midrst_in_wait", 32'(hs.xfer_req), 32'd1);
        applyStimulus(1'b1, 1'b0, 8'h00);
        checkOutput("midrst_wait_req", 32'(hs.xfer_req), 32'd0);
        checkOutput("midrst_wait_cnt", 32'(hs.xfer_cnt), 32'd0);
        checkOutput("midrst_wait_busy", 32'(hs.busy), 32'd0);

        resetFor(2);
        auto_ack    = 1'b1;
        fixed_delay = 0;
        for (int i = 0; i < 6000 && completed < 300; i++)
            applyStimulus(1'b0, accepted < 300, words[(accepted < 300) ? accepted : 299]);
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("stream_cnt", 32'(hs.xfer_cnt), 32'd44);
        checkOutput("stream_left", 32'(exp_q.size()), 32'd0);
        checkOutput("stream_last", 32'(hs.xfer_data), 32'(words[299]));
        checkOutput("stream_busy", 32'(hs.busy), 32'd0);

`ifdef HS_TIMEOUT_EN
        resetFor(2);
        auto_ack    = 1'b0;
        dut_err_cyc = -1;
        applyStimulus(1'b0, 1'b1, 8'h99);
        for (int i = 0; i < 30; i++)
            applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("tmo_err", 32'(hs.err), 32'd1);
        checkOutput("tmo_latency", 32'(dut_err_cyc - m_wait_from), 32'(TIMEOUT));
        ack_val = m_req;
        for (int i = 0; i < 6; i++)
            applyStimulus(1'b0, 1'b1, 8'h11);
        checkOutput("tmo_late_ready", 32'(hs.in_ready), 32'd0);
        checkOutput("tmo_late_cnt", 32'(hs.xfer_cnt), 32'd0);
        checkOutput("tmo_late_err", 32'(hs.err), 32'd1);

        resetFor(2);
        auto_ack    = 1'b1;
        fixed_delay = TIMEOUT;
        applyStimulus(1'b0, 1'b1, 8'h66);
        for (int i = 0; i < 25; i++)
            applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("tmo_race_err", 32'(hs.err), 32'd0);
        checkOutput("tmo_race_cnt", 32'(hs.xfer_cnt), 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cdc_hs_ctrl.md
# cdc_hs_ctrl

Source-side controller for a two-phase (toggle) request/acknowledge handshake that carries a multi-bit word from the `clk_a` domain to another clock domain. It accepts words from a valid/ready producer and holds each word stable on `xfer_data`. After a configurable settle delay it toggles `xfer_req`, then waits for the returning acknowledge toggle before accepting the next word. `xfer_req` is crossed to the destination by an `ff_sync` instance, and the destination's acknowledge toggle is crossed back by another `ff_sync` before it reaches `ack_sync`; both synchronizers sit outside this block.

## Interface

Parameters:

- `DATA_W`, default 8: width of the transferred word.
- `SETTLE`, default 2: number of `clk_a` cycles `xfer_data` is held stable before `xfer_req` toggles. Legal range 1..255.
- `TIMEOUT`, default 255: number of cycles to wait for the acknowledge before flagging an error. Legal range 1..65535. Used only with `HS_TIMEOUT_EN`.
- `CNT_W`, default 8: width of the completed-transfer counter.

Ports:

- `clk_a`, in, 1: the only clock; all logic is on its rising edge.
- `rst_a`, in, 1: synchronous, active-high reset.
- `in_valid`, in, 1: producer has a word.
- `in_data`, in, DATA_W: producer word.
- `in_ready`, out, 1: block can accept a word this cycle.
- `xfer_data`, out, DATA_W: registered word presented to the destination domain.
- `xfer_req`, out, 1: registered request toggle, driven to `ff_sync`.
- `ack_sync`, in, 1: acknowledge toggle, already synchronized into `clk_a`.
- `busy`, out, 1: high in any state other than IDLE.
- `xfer_cnt`, out, CNT_W: count of completed transfers; wraps modulo 2^CNT_W.
- `err`, out, 1: sticky timeout flag. Tied to 0 without `HS_TIMEOUT_EN`.

## Operation

The controller has four states: IDLE, SETUP, WAIT_ACK and ERR. ERR exists only with `HS_TIMEOUT_EN`.

- **Reset values:** state IDLE, `xfer_req`=0, `xfer_data`=0, `xfer_cnt`=0, `err`=0, settle and timeout counters 0.
- **Reset priority:** `rst_a` overrides every other event.
- **Reset mid-transfer:** the transfer is abandoned with no count increment. The destination side must be reset in the same window.

State behaviour:

- **IDLE:**
  - `in_ready` = (`ack_sync` == `xfer_req`), combinational.
  - A mismatch in IDLE (destination not yet realigned after reset) holds `in_ready` low until the two match.
  - On `in_valid && in_ready`: capture `in_data` into `xfer_data`, load settle counter with `SETTLE`-1, go to SETUP.
- **SETUP:**
  - `in_ready`=0; `xfer_data` is frozen.
  - If the settle counter is 0: toggle `xfer_req`, clear the timeout counter, go to WAIT_ACK. Otherwise decrement the counter.
- **WAIT_ACK:**
  - `in_ready`=0.
  - When `ack_sync` == `xfer_req`: increment `xfer_cnt` (wrapping from all-ones to 0), go to IDLE.
  - Otherwise increment the timeout counter.
- **ERR:**
  - `err`=1, `busy`=1, `in_ready`=0.
  - Left only by reset; `ack_sync` is ignored.
- `xfer_data` changes only on an accept in IDLE. `in_data` is never passed through combinationally.

## Timing

- Accept at rising edge N: `xfer_data` is valid after edge N; `xfer_req` toggles at edge N+`SETTLE`.
- If `ack_sync` first matches `xfer_req` when sampled at edge M:
  - the state is IDLE after M;
  - `xfer_cnt` is updated after M;
  - `in_ready` can be high in cycle M+1, so the next accept is at edge M+1 at the earliest.
- Minimum accept-to-accept spacing is `SETTLE`+2 cycles, reached when `ack_sync` toggles in the cycle after the `xfer_req` toggle.
- **Timeout:** if WAIT_ACK is entered at edge R with no match, ERR is entered at edge R+`TIMEOUT`.
- **Ack and timeout on the same edge:** the acknowledge wins; the transfer completes and `err` stays 0.
- `busy` is registered from the state and is high from edge N until edge M.

## Configuration

- Macro: `HS_TIMEOUT_EN`.
- **Defined:** the timeout counter (16 bits), the ERR state and the `err` flag are built.
- **Undefined:**
  - No timeout counter and no ERR state; WAIT_ACK waits indefinitely.
  - `err` is the constant 0; the `TIMEOUT` parameter is ignored.
  - All other behaviour is identical.

## Test plan

1. **Reset values:** hold `rst_a` for 3 cycles, then check `xfer_req`=0, `xfer_data`=0, `xfer_cnt`=0, `in_ready`=1, `busy`=0, `err`=0.
2. **Single transfer:** `SETTLE`=2, `in_data`=0xA5 accepted at edge N; loop `xfer_req` back to `ack_sync` through a 2-cycle delay. Expect `xfer_data`=0xA5 after N, `xfer_req` 0→1 at N+2, `xfer_cnt`=1 and IDLE at N+4, accept possible at N+5.
3. **Back-to-back stream:** 300 words with `in_valid` held high and a random 1–6 cycle ack loopback. Every word appears on `xfer_data`, in order, exactly once per `xfer_req` toggle; `xfer_cnt` wraps 255→0 and reads 44 at the end.
4. **Misaligned ack after reset:** force `ack_sync`=1 with `xfer_req`=0 after reset. `in_ready` stays 0 and no accept occurs until `ack_sync` returns to 0.
5. **Timeout (`HS_TIMEOUT_EN`, `TIMEOUT`=10):** no ack after the request toggle. `err`=1 exactly 10 cycles after WAIT_ACK entry; a later ack is ignored and `in_ready` stays 0 until reset. With the acknowledge arriving on the 10th cycle, the transfer completes and `err`=0.
6. **Reset mid-transfer:** assert `rst_a` during SETUP and again during WAIT_ACK. Outputs return to their reset values on the next edge and `xfer_cnt` is unchanged from 0.
